// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO and its clients: read-latency limits,
// skid-buffer sizing and the common valid/ready stream bundle.
package fifo_pkg;

    localparam int unsigned READ_LATENCY_MIN = 1;
    localparam int unsigned READ_LATENCY_MAX = 2;
    localparam int unsigned STREAM_W_MAX     = 72;

    // One entry per in-flight read plus two, so a stalled consumer never forces a drop.
    function automatic int unsigned fifo_cap(input int unsigned read_latency);
        return read_latency + 2;
    endfunction

    typedef struct packed {
        logic                    valid;
        logic                    ready;
        logic [STREAM_W_MAX-1:0] data;
    } stream_t;

endpackage

// File: rtl/skid_ring_buf.sv
// Small ring buffer absorbing the FIFO read latency: CAP entries, write/read pointers and
// an occupancy count, all cleared by a synchronous flush.
module skid_ring_buf
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CAP   = fifo_cap(READ_LATENCY_MIN),
    localparam int unsigned PTR_W = $clog2(CAP),
    localparam int unsigned OCC_W = $clog2(CAP + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [OCC_W-1:0] occupancy
);

    logic [WIDTH-1:0] mem_q [CAP];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             do_pop;

    // CAP is usually not a power of two, so wrap by compare-and-clear.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(CAP - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop   = rd_en && (occ_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({wr_en, do_pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int unsigned i = 0; i < CAP; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (wr_en && !flush) mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data   = mem_q[rd_ptr_q];
    assign occupancy = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer of the block-RAM FIFO: issues read requests, tracks words in flight and
// presents buffered words as a valid/ready stream with a delivered-word counter.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               fifo_empty,
    output logic               fifo_read_req,
    input  logic [WIDTH-1:0]   fifo_read_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy,
    output logic [COUNT_W-1:0] word_count
);

    localparam int unsigned CAP   = fifo_cap(READ_LATENCY);
    localparam int unsigned OCC_W = $clog2(CAP + 1);

    logic [READ_LATENCY-1:0] inflight_q, inflight_d;
    logic [COUNT_W-1:0]      count_q, count_d;
    logic [OCC_W-1:0]        occupancy;
    logic [OCC_W-1:0]        inflight_cnt;
    logic                    capture;
    logic                    pop;

    always_comb begin
        inflight_cnt = '0;
        for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + OCC_W'(inflight_q[i]);
        end
        // Reserve a slot for every outstanding read; out_ready deliberately not used here.
        fifo_read_req = !fifo_empty && !flush && ((occupancy + inflight_cnt) < OCC_W'(CAP));
        inflight_d    = flush ? '0 : READ_LATENCY'({inflight_q, fifo_read_req});
        capture       = inflight_q[READ_LATENCY-1] && !flush;
        out_valid     = (occupancy != '0) && !flush;
        pop           = out_valid && out_ready;
        count_d       = pop ? count_q + 1'b1 : count_q;
        busy          = (occupancy != '0) || (inflight_q != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
        end
    end

    skid_ring_buf #(
        .WIDTH (WIDTH),
        .CAP   (CAP)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .wr_en     (capture),
        .wr_data   (fifo_read_data),
        .rd_en     (pop),
        .rd_data   (out_data),
        .occupancy (occupancy)
    );

    assign word_count = count_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: two readers (READ_LATENCY 1 and 2) run side by side on identical stimulus,
// each fed by its own behavioural FIFO read port.
module tb_fifo_stream_reader;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned COUNT_W   = 16;
    localparam int          MEM_DEPTH = 2048;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic flush, out_ready, force_empty, stream_mode;

    logic [WIDTH-1:0] mem [MEM_DEPTH];
    int               wr_idx = 0;

    logic               fifo_empty     [2];
    logic               fifo_read_req  [2];
    logic [WIDTH-1:0]   fifo_read_data [2];
    logic               out_valid      [2];
    logic [WIDTH-1:0]   out_data       [2];
    logic               busy           [2];
    logic [COUNT_W-1:0] word_count     [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int unsigned LAT = g + 1;
        int               rd_idx = 0;
        int               reads  = 0;
        logic [WIDTH-1:0] pipe [2];

        // FIFO shares reset_n: asserting it discards everything not yet read.
        assign fifo_empty[g]     = force_empty || (!stream_mode && (rd_idx == wr_idx));
        assign fifo_read_data[g] = pipe[LAT-1];

        always @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd_idx  <= wr_idx;
                pipe[0] <= '0;
                pipe[1] <= '0;
            end else begin
                if (fifo_read_req[g]) begin
                    pipe[0] <= stream_mode ? WIDTH'(rd_idx) : mem[rd_idx % MEM_DEPTH];
                    rd_idx  <= rd_idx + 1;
                    reads   <= reads + 1;
                end
                pipe[1] <= pipe[0];
            end
        end

        fifo_stream_reader #(
            .WIDTH        (WIDTH),
            .READ_LATENCY (LAT),
            .COUNT_W      (COUNT_W)
        ) u_dut (
            .clk            (clk),
            .reset_n        (reset_n),
            .fifo_empty     (fifo_empty[g]),
            .fifo_read_req  (fifo_read_req[g]),
            .fifo_read_data (fifo_read_data[g]),
            .flush          (flush),
            .out_valid      (out_valid[g]),
            .out_ready      (out_ready),
            .out_data       (out_data[g]),
            .busy           (busy[g]),
            .word_count     (word_count[g])
        );
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        flush = 1'b0; out_ready = 1'b0; force_empty = 1'b1; stream_mode = 1'b0;
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic load(input logic [WIDTH-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_idx % MEM_DEPTH] = first + WIDTH'(i);
            wr_idx++;
        end
    endtask

    task automatic test_reset();
        flush = 1'b0; out_ready = 1'b1; force_empty = 1'b0; stream_mode = 1'b0;
        reset_n = 1'b0;
        step(2);
        for (int g = 0; g < 2; g++) begin
            n_tests += 5;
            if (out_valid[g] !== 1'b0) begin
                n_fail++; $display("FAIL reset_out_valid lane%0d: got %b want 0", g, out_valid[g]);
            end
            if (out_data[g] !== '0) begin
                n_fail++; $display("FAIL reset_out_data lane%0d: got %h want 00", g, out_data[g]);
            end
            if (fifo_read_req[g] !== 1'b0) begin
                n_fail++; $display("FAIL reset_read_req lane%0d: got %b want 0", g, fifo_read_req[g]);
            end
            if (busy[g] !== 1'b0) begin
                n_fail++; $display("FAIL reset_busy lane%0d: got %b want 0", g, busy[g]);
            end
            if (word_count[g] !== '0) begin
                n_fail++; $display("FAIL reset_count lane%0d: got %h want 0", g, word_count[g]);
            end
        end
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic test_stream();
        logic exp_v;
        do_reset();
        load(8'h01, 8);
        out_ready = 1'b1; force_empty = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            for (int g = 0; g < 2; g++) begin
                exp_v = (k >= g + 2) && (k <= g + 9);
                n_tests++;
                if (out_valid[g] !== exp_v) begin
                    n_fail++;
                    $display("FAIL stream_valid lane%0d clk%0d: got %b want %b", g, k, out_valid[g], exp_v);
                end
                if (exp_v) begin
                    n_tests++;
                    if (out_data[g] !== WIDTH'(k - g - 1)) begin
                        n_fail++;
                        $display("FAIL stream_data lane%0d clk%0d: got %h want %h", g, k, out_data[g], WIDTH'(k - g - 1));
                    end
                end
            end
        end
        for (int g = 0; g < 2; g++) begin
            n_tests += 2;
            if (word_count[g] !== 16'd8) begin
                n_fail++; $display("FAIL stream_count lane%0d: got %0d want 8", g, word_count[g]);
            end
            if (busy[g] !== 1'b0) begin
                n_fail++; $display("FAIL stream_busy lane%0d: got %b want 0", g, busy[g]);
            end
        end
    endtask

    task automatic test_stall();
        int r0, r1;
        do_reset();
        load(8'h01, 8);
        r0 = g_lane[0].reads; r1 = g_lane[1].reads;
        force_empty = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            for (int g = 0; g < 2; g++) begin
                if (k >= g + 2) begin
                    n_tests++;
                    if (out_valid[g] !== 1'b1 || out_data[g] !== 8'h01) begin
                        n_fail++;
                        $display("FAIL stall_hold lane%0d clk%0d: got v=%b d=%h want v=1 d=01", g, k, out_valid[g], out_data[g]);
                    end
                end
            end
        end
        n_tests += 2;
        if (g_lane[0].reads - r0 !== 3) begin
            n_fail++; $display("FAIL stall_reads lane0: got %0d want 3", g_lane[0].reads - r0);
        end
        if (g_lane[1].reads - r1 !== 4) begin
            n_fail++; $display("FAIL stall_reads lane1: got %0d want 4", g_lane[1].reads - r1);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            for (int g = 0; g < 2; g++) begin
                n_tests++;
                if (out_valid[g] !== 1'b1 || out_data[g] !== WIDTH'(j + 1)) begin
                    n_fail++;
                    $display("FAIL stall_drain lane%0d word%0d: got v=%b d=%h want v=1 d=%h", g, j, out_valid[g], out_data[g], WIDTH'(j + 1));
                end
            end
            step(1);
        end
        for (int g = 0; g < 2; g++) begin
            n_tests += 2;
            if (out_valid[g] !== 1'b0) begin
                n_fail++; $display("FAIL stall_end_valid lane%0d: got %b want 0", g, out_valid[g]);
            end
            if (word_count[g] !== 16'd8) begin
                n_fail++; $display("FAIL stall_count lane%0d: got %0d want 8", g, word_count[g]);
            end
        end
    endtask

    task automatic test_random();
        int exp_idx [2];
        int got [2];
        int cycles, bad_req, bad_occ;
        do_reset();
        exp_idx[0] = wr_idx; exp_idx[1] = wr_idx;
        got[0] = 0; got[1] = 0;
        cycles = 0; bad_req = 0; bad_occ = 0;
        for (int i = 0; i < 1000; i++) begin
            mem[wr_idx % MEM_DEPTH] = WIDTH'($urandom);
            wr_idx++;
        end
        while ((got[0] < 1000 || got[1] < 1000) && cycles < 20000) begin
            @(negedge clk);
            out_ready   = 1'($urandom_range(0, 1));
            force_empty = ($urandom_range(0, 3) == 0);
            #1;
            for (int g = 0; g < 2; g++) begin
                if (fifo_read_req[g] && fifo_empty[g]) bad_req++;
                if (out_valid[g] && out_ready) begin
                    n_tests++;
                    if (out_data[g] !== mem[exp_idx[g] % MEM_DEPTH]) begin
                        n_fail++;
                        $display("FAIL random_order lane%0d word%0d: got %h want %h", g, got[g], out_data[g], mem[exp_idx[g] % MEM_DEPTH]);
                    end
                    exp_idx[g]++;
                    got[g]++;
                end
            end
            if (g_lane[0].u_dut.u_buf.occ_q > 3) bad_occ++;
            if (g_lane[1].u_dut.u_buf.occ_q > 4) bad_occ++;
            cycles++;
        end
        force_empty = 1'b1;
        out_ready   = 1'b0;
        n_tests += 4;
        if (got[0] != 1000) begin n_fail++; $display("FAIL random_words lane0: got %0d want 1000", got[0]); end
        if (got[1] != 1000) begin n_fail++; $display("FAIL random_words lane1: got %0d want 1000", got[1]); end
        if (bad_req != 0) begin n_fail++; $display("FAIL random_req_while_empty: got %0d want 0", bad_req); end
        if (bad_occ != 0) begin n_fail++; $display("FAIL random_occ_over_cap: got %0d want 0", bad_occ); end
        step(1);
    endtask

    task automatic test_flush();
        logic             seen  [2];
        logic [WIDTH-1:0] first [2];
        logic [15:0]      wc    [2];
        do_reset();
        load(8'h10, 6);
        force_empty = 1'b0;
        // lane0 now holds 0x10,0x11 with 0x12 in flight; lane1 holds 0x10 with 0x11,0x12 in flight
        step(3);
        n_tests++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h10) begin
            n_fail++; $display("FAIL flush_pre lane0: got v=%b d=%h want v=1 d=10", out_valid[0], out_data[0]);
        end
        flush = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            n_tests += 2;
            if (out_valid[g] !== 1'b0) begin
                n_fail++; $display("FAIL flush_valid lane%0d: got %b want 0", g, out_valid[g]);
            end
            if (fifo_read_req[g] !== 1'b0) begin
                n_fail++; $display("FAIL flush_req lane%0d: got %b want 0", g, fifo_read_req[g]);
            end
        end
        step(1);
        flush = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            n_tests += 2;
            if (out_valid[g] !== 1'b0) begin
                n_fail++; $display("FAIL flush_after_valid lane%0d: got %b want 0", g, out_valid[g]);
            end
            if (busy[g] !== 1'b0) begin
                n_fail++; $display("FAIL flush_after_busy lane%0d: got %b want 0", g, busy[g]);
            end
        end
        out_ready = 1'b1;
        seen[0] = 1'b0; seen[1] = 1'b0;
        first[0] = '0; first[1] = '0; wc[0] = '1; wc[1] = '1;
        for (int k = 0; k < 10; k++) begin
            step(1);
            for (int g = 0; g < 2; g++) begin
                if (!seen[g] && out_valid[g]) begin
                    seen[g] = 1'b1; first[g] = out_data[g]; wc[g] = word_count[g];
                end
            end
        end
        for (int g = 0; g < 2; g++) begin
            n_tests += 2;
            if (!seen[g] || first[g] !== 8'h13) begin
                n_fail++; $display("FAIL flush_next_word lane%0d: got seen=%b d=%h want 13", g, seen[g], first[g]);
            end
            if (wc[g] !== 16'd0) begin
                n_fail++; $display("FAIL flush_count lane%0d: got %0d want 0", g, wc[g]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic             seen  [2];
        logic [WIDTH-1:0] first [2];
        do_reset();
        load(8'h20, 8);
        out_ready = 1'b1; force_empty = 1'b0;
        step(4);
        for (int g = 0; g < 2; g++) begin
            n_tests++;
            if (out_valid[g] !== 1'b1 || word_count[g] === '0) begin
                n_fail++; $display("FAIL areset_pre lane%0d: got v=%b cnt=%0d want v=1 cnt>0", g, out_valid[g], word_count[g]);
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            n_tests += 4;
            if (out_valid[g] !== 1'b0) begin
                n_fail++; $display("FAIL areset_valid lane%0d: got %b want 0", g, out_valid[g]);
            end
            if (fifo_read_req[g] !== 1'b0) begin
                n_fail++; $display("FAIL areset_req lane%0d: got %b want 0", g, fifo_read_req[g]);
            end
            if (busy[g] !== 1'b0) begin
                n_fail++; $display("FAIL areset_busy lane%0d: got %b want 0", g, busy[g]);
            end
            if (word_count[g] !== '0) begin
                n_fail++; $display("FAIL areset_count lane%0d: got %0d want 0", g, word_count[g]);
            end
        end
        step(1);
        reset_n = 1'b1;
        force_empty = 1'b1;
        step(1);
        load(8'h40, 8);
        force_empty = 1'b0;
        seen[0] = 1'b0; seen[1] = 1'b0; first[0] = '0; first[1] = '0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            for (int g = 0; g < 2; g++) begin
                if (!seen[g] && out_valid[g]) begin
                    seen[g] = 1'b1; first[g] = out_data[g];
                end
            end
        end
        for (int g = 0; g < 2; g++) begin
            n_tests++;
            if (!seen[g] || first[g] !== 8'h40) begin
                n_fail++; $display("FAIL areset_restart lane%0d: got seen=%b d=%h want 40", g, seen[g], first[g]);
            end
        end
    endtask

    task automatic test_count_wrap();
        int cycles;
        do_reset();
        stream_mode = 1'b1; out_ready = 1'b1; force_empty = 1'b0;
        cycles = 0;
        while (word_count[0] !== 16'hFFFF && cycles < 70000) begin
            step(1);
            cycles++;
        end
        out_ready = 1'b0;
        step(1);
        // lane1 starts delivering one clock later, so it trails lane0 by one word
        n_tests += 2;
        if (word_count[0] !== 16'hFFFF) begin
            n_fail++; $display("FAIL wrap_pre lane0: got %h want ffff", word_count[0]);
        end
        if (word_count[1] !== 16'hFFFE) begin
            n_fail++; $display("FAIL wrap_pre lane1: got %h want fffe", word_count[1]);
        end
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        n_tests += 2;
        if (word_count[0] !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_zero lane0: got %h want 0000", word_count[0]);
        end
        if (word_count[1] !== 16'hFFFF) begin
            n_fail++; $display("FAIL wrap_one lane1: got %h want ffff", word_count[1]);
        end
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        n_tests += 2;
        if (word_count[0] !== 16'h0001) begin
            n_fail++; $display("FAIL wrap_after lane0: got %h want 0001", word_count[0]);
        end
        if (word_count[1] !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_zero lane1: got %h want 0000", word_count[1]);
        end
    endtask

    initial begin
        flush = 1'b0; out_ready = 1'b0; force_empty = 1'b1; stream_mode = 1'b0;
        #1;
        test_reset();
        test_stream();
        test_stall();
        test_random();
        test_flush();
        test_async_reset();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
